stringify_tx: RTL and testbench
===============================

// Module: stringify_tx
// PURPOSE
//  Inverse of the matrixify block: takes a 4x4 AES state matrix, rebuilds the flat 128-bit
//  string, and streams it out one byte per handshake. Sits at the output of the round datapath,
//  feeding ciphertext/plaintext to byte-wide I/O.
//  Mapping: rawstring[8*(4*c+r) +: 8] = matrix[r][c] (column-major; matrix[3][3] = byte 15).
// PARAMETERS
//  MSB_FIRST   1   1: stream byte 15 (matrix[3][3]) first; 0: stream byte 0 (matrix[0][0]) first
// PORTS
//  clk          in   1        single clock, all state on posedge
//  rst_n        in   1        asynchronous, active-low reset
//  matrix       in   8x[4][4] state matrix, sampled only on load (in_valid & in_ready)
//  in_valid     in   1        matrix valid
//  in_ready     out  1        block idle, can accept a matrix
//  rawstring    out  128      registered flat string of the last loaded matrix
//  raw_valid    out  1        1-cycle pulse: rawstring updated
//  byte_out     out  8        current stream byte
//  byte_valid   out  1        byte_out valid
//  byte_ready   in   1        sink accepts byte_out (transfer = byte_valid & byte_ready)
//  byte_last    out  1        final byte of the frame (qualified by byte_valid)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, rawstring=0, raw_valid=0, byte_out=0,
//   byte_valid=0, byte_last=0, in_ready=1. Reset mid-frame aborts; no partial resume.
//  FSM: IDLE -> SEND on load; SEND -> IDLE on transfer with byte_last (or -> CSUM, see below).
//  IDLE: in_ready=1, byte_valid=0. On load: rawstring <= flattened matrix, raw_valid=1 next cycle,
//   idx <= 0, enter SEND. Latency: first byte_valid one cycle after the load edge.
//  SEND: in_ready=0; in_valid ignored (matrix not sampled). byte_valid=1;
//   byte_out = rawstring byte (MSB_FIRST ? 15-idx : idx). Each transfer: idx++.
//   byte_valid stalls with byte_out/byte_last held stable while byte_ready=0.
//  byte_last=1 when idx=15 (no CSUM). idx is 4-bit plus terminal flag; never wraps into a new frame.
//  Back-to-back: in_ready rises the cycle after the last transfer; min 17 cycles/frame.
//  rawstring and its contents hold until the next load. byte_ready while byte_valid=0 has no effect.
// CONFIGURATION
//  STRINGIFY_CSUM_EN defined: after byte 15, state CSUM emits a 17th byte = XOR of all 16 bytes,
//   byte_last moves to the checksum byte; checksum is accumulated during SEND, cleared on load/reset.
//  Undefined: 16-byte frames, no CSUM state, no checksum register.
// TESTING
//  Vector V: rawstring 128'h121b1904637a127974620d1577056458 (m[3][3]=12, m[2][2]=7a, m[0][0]=58).
//  1 Load V, byte_ready=1 -> raw_valid pulse, rawstring==V, bytes 12,1b,19,..,64,58; byte_last on 58.
//  2 MSB_FIRST=0, load V -> first byte 58 (m[0][0]), last byte 12 (m[3][3]) with byte_last.
//  3 Hold byte_ready=0 5 cycles at byte 3 -> byte_out stays 04, byte_valid=1, in_ready=0; resume ok.
//  4 Pulse in_valid with other matrix during SEND -> ignored; stream still V; rawstring still V.
//  5 Drop rst_n at byte 7 -> immediately byte_valid=0, rawstring=0, in_ready=1; reload V streams from 12.
//  6 STRINGIFY_CSUM_EN, load V -> 17 bytes, 17th = 26 with byte_last; without macro 16 bytes, last=58.

Source files
------------

// File: rtl/stringify_tx.sv
// stringify_tx: flattens a 4x4 AES state matrix (column-major) and streams it one byte per handshake.
// Optional build macro STRINGIFY_CSUM_EN appends a 17th XOR-checksum byte to every frame.
module stringify_tx #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0][3:0][7:0]  matrix,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [127:0]          rawstring,
  output logic                  raw_valid,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  byte_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_CSUM = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_idx;
  logic [127:0]   w_flat;
  logic [3:0]     w_sel;
  logic [7:0]     w_byte;
  logic           w_load;
  logic           w_xfer;

  assign w_load = in_valid && (r_state == S_IDLE);
  assign w_xfer = byte_valid && byte_ready;

  // Column-major flattening: byte 4*c+r of the string holds matrix[r][c].
  always_comb begin
    w_flat = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_flat[8*(4*c+r) +: 8] = matrix[r][c];
      end
    end
  end

  assign w_sel  = MSB_FIRST ? (4'd15 - r_idx) : r_idx;
  assign w_byte = rawstring[{w_sel, 3'b000} +: 8];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_load) w_next = S_SEND;
      S_SEND: begin
        if (w_xfer && (r_idx == 4'd15)) begin
`ifdef STRINGIFY_CSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_IDLE;
`endif
        end
      end
      S_CSUM: if (w_xfer) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rawstring <= '0;
      raw_valid <= 1'b0;
      r_idx     <= '0;
    end else begin
      raw_valid <= w_load;
      if (w_load) begin
        rawstring <= w_flat;
        r_idx     <= '0;
      end else if (w_xfer && (r_state == S_SEND) && (r_idx != 4'd15)) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

`ifdef STRINGIFY_CSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_load) begin
      r_csum <= '0;
    end else if (w_xfer && (r_state == S_SEND)) begin
      r_csum <= r_csum ^ w_byte;
    end
  end
`endif

  always_comb begin
    in_ready   = 1'b0;
    byte_valid = 1'b0;
    byte_out   = '0;
    byte_last  = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = w_byte;
`ifndef STRINGIFY_CSUM_EN
        byte_last  = (r_idx == 4'd15);
`endif
      end
`ifdef STRINGIFY_CSUM_EN
      S_CSUM: begin
        byte_valid = 1'b1;
        byte_out   = r_csum;
        byte_last  = 1'b1;
      end
`endif
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_stringify_tx.sv
// Self-checking bench for stringify_tx: MSB-first and LSB-first instances driven in lockstep,
// compared against a byte-list model built straight from the column-major mapping.
module tb_stringify_tx;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0][3:0][7:0] matrix;
  logic                 in_valid;
  logic                 byte_ready;

  logic         m_in_ready, m_raw_valid, m_byte_valid, m_byte_last;
  logic [127:0] m_rawstring;
  logic [7:0]   m_byte_out;
  logic         l_in_ready, l_raw_valid, l_byte_valid, l_byte_last;
  logic [127:0] l_rawstring;
  logic [7:0]   l_byte_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stringify_tx #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .matrix(matrix), .in_valid(in_valid), .in_ready(m_in_ready),
    .rawstring(m_rawstring), .raw_valid(m_raw_valid), .byte_out(m_byte_out),
    .byte_valid(m_byte_valid), .byte_ready(byte_ready), .byte_last(m_byte_last)
  );

  stringify_tx #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .matrix(matrix), .in_valid(in_valid), .in_ready(l_in_ready),
    .rawstring(l_rawstring), .raw_valid(l_raw_valid), .byte_out(l_byte_out),
    .byte_valid(l_byte_valid), .byte_ready(byte_ready), .byte_last(l_byte_last)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: string byte b is matrix[b%4][b/4].
  function automatic logic [127:0] flatten(input logic [3:0][3:0][7:0] m);
    logic [127:0] f;
    f = '0;
    for (int b = 0; b < 16; b++) f[8*b +: 8] = m[b % 4][b / 4];
    return f;
  endfunction

  function automatic logic [3:0][3:0][7:0] rand_matrix();
    logic [3:0][3:0][7:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 8'($urandom);
    return m;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},   {m_in_ready, l_in_ready}, 2'b11);
    check({tag, "_byte_valid"}, {m_byte_valid, l_byte_valid}, 2'b00);
    check({tag, "_byte_last"},  {m_byte_last, l_byte_last}, 2'b00);
    check({tag, "_raw_valid"},  {m_raw_valid, l_raw_valid}, 2'b00);
    check({tag, "_byte_out"},   {m_byte_out, l_byte_out}, 16'h0000);
    check({tag, "_rawstring_m"}, m_rawstring, '0);
    check({tag, "_rawstring_l"}, l_rawstring, '0);
  endtask

  // mode 0: plain, 1: stall 5 cycles at byte 3, 2: in_valid pulse during SEND, 3: reset at byte 7
  task automatic run_frame(input logic [3:0][3:0][7:0] m, input int mode, input bit rand_ready);
    logic [127:0] flat;
    logic [7:0]   em[$];
    logic [7:0]   el[$];
    logic [7:0]   x;
    int           n, k, cyc, stall;
    flat = flatten(m);
    x = '0;
    for (int b = 0; b < 16; b++) begin
      em.push_back(flat[8*(15-b) +: 8]);
      el.push_back(flat[8*b +: 8]);
      x ^= flat[8*b +: 8];
    end
`ifdef STRINGIFY_CSUM_EN
    em.push_back(x);
    el.push_back(x);
`endif
    n = em.size();

    @(negedge clk);
    check("in_ready_idle", {m_in_ready, l_in_ready}, 2'b11);
    matrix     = m;
    in_valid   = 1'b1;
    byte_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    matrix   = rand_matrix();
    check("raw_valid_pulse", {m_raw_valid, l_raw_valid}, 2'b11);
    check("rawstring_m", m_rawstring, flat);
    check("rawstring_l", l_rawstring, flat);

    k = 0; cyc = 0; stall = 0;
    while (k < n && cyc < 400) begin
      if (mode == 3 && k == 7) begin
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && k == 3 && stall < 5) begin
        byte_ready = 1'b0;
        stall++;
      end
      if (mode == 2 && k == 3) begin
        in_valid = 1'b1;
        matrix   = rand_matrix();
      end else begin
        in_valid = 1'b0;
      end
      check("byte_valid", {m_byte_valid, l_byte_valid}, 2'b11);
      check("byte_out_msb", m_byte_out, em[k]);
      check("byte_out_lsb", l_byte_out, el[k]);
      check("byte_last", {m_byte_last, l_byte_last}, {2{k == n - 1}});
      check("in_ready_send", {m_in_ready, l_in_ready}, 2'b00);
      if (byte_ready) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("frame_len", 128'(k), 128'(n));
    check("in_ready_after", {m_in_ready, l_in_ready}, 2'b11);
    check("byte_valid_after", {m_byte_valid, l_byte_valid}, 2'b00);
    check("raw_valid_after", {m_raw_valid, l_raw_valid}, 2'b00);
    check("rawstring_hold_m", m_rawstring, flat);
    check("rawstring_hold_l", l_rawstring, flat);
    byte_ready = 1'b0;
  endtask

  initial begin
    logic [127:0]         vec;
    logic [3:0][3:0][7:0] mv;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    byte_ready = 1'b0;
    matrix     = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    vec = 128'h121b1904637a127974620d1577056458;
    for (int b = 0; b < 16; b++) mv[b % 4][b / 4] = vec[8*b +: 8];

    run_frame(mv, 0, 1'b0);
    run_frame(mv, 1, 1'b0);
    run_frame(mv, 2, 1'b0);
    run_frame(mv, 3, 1'b0);
    run_frame(mv, 0, 1'b0);
    repeat (20) run_frame(rand_matrix(), 0, 1'b1);
    run_frame(rand_matrix(), 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
